// File: rtl/poly_byte_encode_pkg.sv
// Shared KEM types: polynomial container, ML-KEM constants and the encode/decode FSM states.
// Also holds the fixed widths used between poly_byte_encode and its gearbox.
package poly_byte_encode_pkg;

  localparam int ML_KEM_N = 256;
  localparam int ML_KEM_Q = 3329;
  localparam int COEFF_W  = 12;
  localparam int OUT_W    = 64;
  // Wide enough for any D in 1..12: G <= 64 coeffs per chunk, fill <= 63 + 72.
  localparam int CNT_W    = 7;
  localparam int FILL_W   = 8;

  typedef logic [ML_KEM_N-1:0][COEFF_W-1:0] poly_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STREAM,
    DONE
  } encode_state_t;

  function automatic int gear_coeffs(input int d);
    return (OUT_W + d - 1) / d;
  endfunction

endpackage

// File: rtl/poly_byte_encode_gearbox.sv
// Bit-packing gearbox: appends chunks of up to G D-bit coeffs into an accumulator and
// streams the low 64 bits out with valid/ready holding.
module poly_byte_encode_gearbox
  import poly_byte_encode_pkg::*;
#(
  parameter int D = 12,
  parameter int G = 6
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [D*G-1:0]    chunk_i,
  input  logic [CNT_W-1:0]  n_coeffs_i,
  input  logic              avail_i,
  output logic              take_o,
  output logic [OUT_W-1:0]  tdata_o,
  output logic              tvalid_o,
  input  logic              tready_i,
  output logic [FILL_W-1:0] fill_o
);

  localparam int ACC_W = OUT_W + G * D;

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [ACC_W-1:0]  shifted, mask, chunk_ext;
  logic [FILL_W-1:0] base;
  logic              emit;
  int                nbits;

  assign tvalid_o = fill_q >= FILL_W'(OUT_W);
  assign tdata_o  = acc_q[OUT_W-1:0];
  assign fill_o   = fill_q;

  // Append is decided on the post-emit fill so a beat and a chunk can share a cycle.
  always_comb begin
    emit      = tvalid_o && tready_i;
    shifted   = emit ? (acc_q >> OUT_W) : acc_q;
    base      = emit ? (fill_q - FILL_W'(OUT_W)) : fill_q;
    take_o    = avail_i && (base < FILL_W'(OUT_W));
    nbits     = int'(n_coeffs_i) * D;
    mask      = (ACC_W'(1) << nbits) - ACC_W'(1);
    chunk_ext = ACC_W'(chunk_i) & mask;
    acc_d     = shifted;
    fill_d    = base;
    if (take_o) begin
      acc_d  = shifted | (chunk_ext << base);
      fill_d = base + FILL_W'(nbits);
    end
  end

  // Bits above fill stay zero, so a fresh packet never sees stale data after an abort.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      acc_q  <= '0;
      fill_q <= '0;
    end else begin
      acc_q  <= acc_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/poly_byte_encode.sv
// ByteEncode_D serialiser: captures a poly_t and streams its D-bit packed form as 64-bit beats.
// Optional range check on captured coeffs is enabled by POLY_ENCODE_RANGE_CHECK_EN.
module poly_byte_encode
  import poly_byte_encode_pkg::*;
#(
  parameter int D = 12
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             run_i,
  input  poly_t            poly_i,
  output logic             busy_o,
  output logic [OUT_W-1:0] tdata_o,
  output logic             tvalid_o,
  input  logic             tready_i,
  output logic             tlast_o,
  output logic             done_o,
  output logic             err_o
);

  localparam int G      = gear_coeffs(D);
  localparam int BEATS  = ML_KEM_N * D / OUT_W;
  localparam int BEAT_W = $clog2(BEATS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  encode_state_t     state_q;
  poly_t             poly_q;
  logic [8:0]        idx_q;
  logic [BEAT_W-1:0] beat_q;
  logic              busy_q, done_q;

  logic [D*G-1:0]    chunk;
  logic [CNT_W-1:0]  n_coeffs;
  logic [8:0]        remaining, cidx;
  logic              avail, take, hs;
  logic [FILL_W-1:0] gb_fill;

  assign remaining = 9'(ML_KEM_N) - idx_q;
  assign avail     = ((state_q == LOAD) || (state_q == STREAM)) && (idx_q < 9'(ML_KEM_N));
  assign n_coeffs  = (remaining < 9'(G)) ? CNT_W'(remaining) : CNT_W'(G);
  assign hs        = tvalid_o && tready_i;

  // Coeffs past the end of the polynomial are zero; the gearbox masks them anyway.
  always_comb begin
    chunk = '0;
    cidx  = '0;
    for (int k = 0; k < G; k++) begin
      cidx = idx_q + 9'(k);
      if (cidx < 9'(ML_KEM_N)) chunk[k*D +: D] = poly_q[cidx[7:0]][D-1:0];
    end
  end

  poly_byte_encode_gearbox #(
    .D (D),
    .G (G)
  ) u_gearbox (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .chunk_i    (chunk),
    .n_coeffs_i (n_coeffs),
    .avail_i    (avail),
    .take_o     (take),
    .tdata_o    (tdata_o),
    .tvalid_o   (tvalid_o),
    .tready_i   (tready_i),
    .fill_o     (gb_fill)
  );

  always_ff @(posedge clk_i) begin
    if ((state_q == IDLE) && run_i) poly_q <= poly_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      beat_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      if (take) idx_q <= idx_q + 9'(n_coeffs);
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (run_i) begin
            state_q <= LOAD;
            idx_q   <= '0;
            beat_q  <= '0;
            busy_q  <= 1'b1;
          end
        end
        LOAD: state_q <= STREAM;
        STREAM: begin
          if (hs) begin
            beat_q <= beat_q + 1'b1;
            if (beat_q == LAST_BEAT) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign tlast_o = tvalid_o && (state_q == STREAM) && (beat_q == LAST_BEAT);

`ifdef POLY_ENCODE_RANGE_CHECK_EN
  logic err_q;

  function automatic logic out_of_range(input poly_t p);
    logic r;
    r = 1'b0;
    for (int i = 0; i < ML_KEM_N; i++) begin
      if (p[i] >= COEFF_W'(ML_KEM_Q)) r = 1'b1;
    end
    return r;
  endfunction

  // Evaluated on the capture edge so the flag is already visible during LOAD.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_q <= 1'b0;
    end else if ((state_q == IDLE) && run_i) begin
      err_q <= out_of_range(poly_i);
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  a_done_fill_empty: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    (state_q == DONE) |-> (gb_fill == '0));

endmodule

// File: tb/tb_poly_byte_encode.sv
// Directed bench for poly_byte_encode: D=12 vector table plus D=1, abort and range-check sequences.
module tb_poly_byte_encode;
  import poly_byte_encode_pkg::*;

`ifdef POLY_ENCODE_RANGE_CHECK_EN
  localparam bit RC_EN = 1'b1;
`else
  localparam bit RC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, run, tready, busy, tvalid, tlast, done, err;
  poly_t       poly;
  logic [63:0] tdata;
  logic        run1, tready1, busy1, tvalid1, tlast1, done1, err1;
  poly_t       poly1;
  logic [63:0] tdata1;

  poly_byte_encode #(.D(12)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .run_i(run), .poly_i(poly), .busy_o(busy),
    .tdata_o(tdata), .tvalid_o(tvalid), .tready_i(tready), .tlast_o(tlast),
    .done_o(done), .err_o(err)
  );

  poly_byte_encode #(.D(1)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .run_i(run1), .poly_i(poly1), .busy_o(busy1),
    .tdata_o(tdata1), .tvalid_o(tvalid1), .tready_i(tready1), .tlast_o(tlast1),
    .done_o(done1), .err_o(err1)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk64(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic chki(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic logic [11:0] coef(input int pat, input int i);
    int v;
    case (pat)
      0: v = i;
      1: v = 12'hFFF;
      2: v = (i % 2 == 1) ? 12'h001 : 12'h800;
      default: v = (i * 37 + 5) ^ 12'h5A5;
    endcase
    return 12'(v);
  endfunction

  function automatic poly_t make_poly(input int pat);
    poly_t p;
    for (int i = 0; i < ML_KEM_N; i++) p[i] = coef(pat, i);
    return p;
  endfunction

  // Reference packer: stream bit j is bit (j mod d) of coeff (j / d).
  function automatic logic [63:0] model_beat(input int pat, input int d, input int w);
    logic [63:0] r;
    logic [11:0] c;
    int j;
    for (int b = 0; b < 64; b++) begin
      j = 64 * w + b;
      c = coef(pat, j / d);
      r[b] = c[j % d];
    end
    return r;
  endfunction

  typedef struct {
    int          pat;
    int          mode;      // 0: tready always 1, 1: random tready
    bit          pulse;     // extra run_i pulses at beats 5, 47 and in DONE
    logic [63:0] exp_first;
    logic [63:0] exp_last;
    int          exp_done;  // expected done_o cycle, 0 = not checked
    logic        exp_err;   // with range check enabled
  } vec_t;

  vec_t        vecs[5];
  logic [63:0] got_beats[48];
  logic        got_last[48];
  int          nb, done_cyc;

  task automatic do_packet(input int pat, input int mode, input bit pulse,
                           input int abort_after, input logic exp_err);
    int          cyc;
    bit          stalled;
    logic [63:0] held;
    for (int i = 0; i < 48; i++) begin
      got_beats[i] = '0;
      got_last[i]  = 1'b0;
    end
    @(negedge clk);
    poly   = make_poly(pat);
    run    = 1'b1;
    tready = 1'b0;
    nb = 0; done_cyc = -1; cyc = 0; stalled = 1'b0; held = '0;
    while (done_cyc < 0 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      run  = 1'b0;
      poly = make_poly(3);
      if (cyc == 1) begin
        chk1("busy_after_run", busy, 1'b1);
        chk1("err_in_load", err, exp_err);
      end
      if (stalled) begin
        chk1("stall_valid_hold", tvalid, 1'b1);
        chk64("stall_data_hold", tdata, held);
      end
      if (abort_after > 0 && nb == abort_after) begin
        rst_n = 1'b0;
        #1;
        chk1("abort_tvalid", tvalid, 1'b0);
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_tlast", tlast, 1'b0);
        chk1("abort_done", done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      tready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (pulse && tvalid && (nb == 5 || nb == 47)) begin
        run  = 1'b1;
        poly = make_poly(1);
      end
      if (tvalid && tready) begin
        if (nb < 48) begin
          got_beats[nb] = tdata;
          got_last[nb]  = tlast;
        end
        nb++;
      end
      stalled = tvalid && !tready;
      held    = tdata;
      if (done) begin
        done_cyc = cyc;
        chk1("busy_in_done", busy, 1'b1);
        if (pulse) begin
          run  = 1'b1;
          poly = make_poly(1);
        end
      end
    end
    if (done_cyc < 0) chki("done_timeout", cyc, -1);
    @(negedge clk);
    run = 1'b0;
    chk1("done_one_cycle", done, 1'b0);
    chk1("busy_after_done", busy, 1'b0);
    chk1("idle_tvalid", tvalid, 1'b0);
    chk1("err_sticky", err, exp_err);
  endtask

  task automatic check_packet(input vec_t v, input int idx);
    chki($sformatf("v%0d_beat_count", idx), nb, 48);
    chk64($sformatf("v%0d_beat0_const", idx), got_beats[0], v.exp_first);
    chk64($sformatf("v%0d_beat47_const", idx), got_beats[47], v.exp_last);
    for (int w = 0; w < 48; w++) begin
      chk64($sformatf("v%0d_beat%0d", idx, w), got_beats[w], model_beat(v.pat, 12, w));
      chk1($sformatf("v%0d_tlast%0d", idx, w), got_last[w], w == 47);
    end
    if (v.exp_done > 0) chki($sformatf("v%0d_done_cycle", idx), done_cyc, v.exp_done);
  endtask

  initial begin
    int cnt, cyc;
    bit seen;

    vecs[0] = '{0, 0, 1'b0, 64'h5004_0030_0200_1000, 64'h0FF0_FE0F_D0FC_0FB0, 50, 1'b0};
    vecs[1] = '{0, 1, 1'b0, 64'h5004_0030_0200_1000, 64'h0FF0_FE0F_D0FC_0FB0, 0,  1'b0};
    vecs[2] = '{1, 0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 50, 1'b1};
    vecs[3] = '{2, 0, 1'b0, 64'h1800_0018_0000_1800, 64'h0018_0000_1800_0018, 50, 1'b0};
    vecs[4] = '{0, 0, 1'b1, 64'h5004_0030_0200_1000, 64'h0FF0_FE0F_D0FC_0FB0, 50, 1'b0};

    rst_n = 1'b0; run = 1'b0; tready = 1'b0; poly = '0;
    run1 = 1'b0; tready1 = 1'b0; poly1 = '0;
    repeat (3) @(negedge clk);
    chk1("rst_tvalid", tvalid, 1'b0);
    chk1("rst_tlast", tlast, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk64("rst_tdata", tdata, 64'h0);
    chk1("rst_tvalid_d1", tvalid1, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      do_packet(vecs[v].pat, vecs[v].mode, vecs[v].pulse, 0, RC_EN && vecs[v].exp_err);
      check_packet(vecs[v], v);
    end

    // Abort after 10 beats, then a clean packet must match the reference.
    do_packet(0, 0, 1'b0, 10, 1'b0);
    chki("abort_beats_before_reset", nb, 10);
    do_packet(0, 0, 1'b0, 0, 1'b0);
    check_packet(vecs[0], 9);

    // Range flag raised by an invalid poly, then cleared by the next valid run.
    do_packet(1, 0, 1'b0, 0, RC_EN);
    do_packet(2, 0, 1'b0, 0, 1'b0);
    check_packet(vecs[3], 8);

    // D=1 build: alternating LSBs give 0xAA.. beats.
    @(negedge clk);
    for (int i = 0; i < ML_KEM_N; i++) poly1[i] = 12'(i % 2);
    run1 = 1'b1;
    tready1 = 1'b1;
    cnt = 0; cyc = 0; seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      run1 = 1'b0;
      if (tvalid1 && tready1) begin
        chk64($sformatf("d1_beat%0d", cnt), tdata1, 64'hAAAA_AAAA_AAAA_AAAA);
        chk1($sformatf("d1_tlast%0d", cnt), tlast1, cnt == 3);
        cnt++;
      end
      if (done1) seen = 1'b1;
    end
    chki("d1_beat_count", cnt, 4);
    chk1("d1_done_seen", seen, 1'b1);
    @(negedge clk);
    chk1("d1_busy_after", busy1, 1'b0);
    chk1("d1_err", err1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
